irq_controller: RTL and testbench

- Interrupt controller between the peripheral interrupt lines and the CPU's `HWInt[7:2]` input.
- Synchronises six asynchronous device requests and latches them as level- or edge-mode pending bits.
- Applies enable masking and fixed-priority nesting. The priority model is a claim/complete handshake, driven by CPU software through a bridge-mapped register window.
- Sits beside the timers on the bridge and is selected by the bridge's address decode.

---
 rtl/irq_controller_pkg.sv | 40 ++++
 rtl/irq_sync_edge.sv | 37 +++
 rtl/irq_controller.sv | 123 ++++++++++++
 tb/tb_irq_controller.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller. The bridge decode and the
// tests use the same register offsets, source count and CLAIM valid position.
package irq_controller_pkg;

  localparam int N_IRQ           = 6;
  localparam int CLAIM_VALID_BIT = 31;

  // Word offsets inside the register window (bridge address [4:2]).
  typedef enum logic [2:0] {
    IRQ_ENABLE    = 3'd0,
    IRQ_MODE      = 3'd1,
    IRQ_PENDING   = 3'd2,
    IRQ_CLAIM     = 3'd3,
    IRQ_COMPLETE  = 3'd4,
    IRQ_INSERVICE = 3'd5,
    IRQ_SWTRIG    = 3'd6,
    IRQ_RESERVED  = 3'd7
  } reg_offset_t;

  typedef logic [N_IRQ-1:0] irq_vec_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } claim_t;

  // Lowest set bit wins: a lower index means a higher priority.
  function automatic claim_t pick_lowest(input irq_vec_t req);
    claim_t c;
    c = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        c.valid = 1'b1;
        c.id    = 3'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser and rising-edge detector.
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : asynchronous device request
//   level      : synchronised request (last flop of the chain)
//   rise       : one-cycle pulse when level goes 0 -> 1
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain[0] <= raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        chain[k] <= chain[k-1];
      end
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Six-source interrupt controller feeding CPU HWInt[7:2].
// Requests are synchronised, latched as level- or edge-mode pending bits,
// masked by ENABLE and nested by fixed priority through a claim/complete
// handshake on a bridge-mapped register window.
//   clk, reset : system clock, asynchronous active-high reset
//   irq_in     : raw device requests, bit i = source i
//   sel/we/re  : bridge select, write and read strobes
//   addr       : word offset (bridge address [4:2]); be: byte enables (be[0] used)
//   wdata      : write data; rdata: combinational read data for addr
//   hwint      : registered interrupt lines to the CPU
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic                sel,
  input  logic                we,
  input  logic                re,
  input  logic [2:0]          addr,
  input  logic [3:0]          be,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [N_IRQ-1:0]    hwint
);

  irq_vec_t    level, rise;
  irq_vec_t    enable, mode, pending, inservice;
  irq_vec_t    pending_nxt, inservice_nxt;
  irq_vec_t    eligible, blocked, candidate;
  claim_t      claim;
  reg_offset_t offset;
  logic        wr, claim_fire;

  // Only byte 0 carries fields.
  logic unused_bits;
  assign unused_bits = ^{be[3:1], wdata[31:N_IRQ]};

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .raw   (irq_in[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  assign offset = reg_offset_t'(addr);
  assign wr     = sel & we & be[0];

  // A source is blocked by anything in service at its own or a higher priority.
  always_comb begin
    blocked[0] = inservice[0];
    for (int i = 1; i < N_IRQ; i++) begin
      blocked[i] = blocked[i-1] | inservice[i];
    end
  end

  assign eligible   = pending & enable;
  assign candidate  = eligible & ~blocked;
  assign claim      = pick_lowest(candidate);
  assign claim_fire = sel & re & (offset == IRQ_CLAIM) & claim.valid;

  // NOTE: every variable in this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    pending_nxt   = pending;
    inservice_nxt = inservice;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mode[i]) begin
        // Clears first, sets last: a simultaneous edge or SWTRIG wins.
        if (wr && offset == IRQ_PENDING && wdata[i]) pending_nxt[i] = 1'b0;
        if (claim_fire && claim.id == 3'(i))         pending_nxt[i] = 1'b0;
        if (rise[i] || (wr && offset == IRQ_SWTRIG && wdata[i])) begin
          pending_nxt[i] = 1'b1;
        end
      end else begin
        pending_nxt[i] = level[i];
      end

      if (claim_fire && claim.id == 3'(i)) inservice_nxt[i] = 1'b1;
      if (wr && offset == IRQ_COMPLETE && wdata[2:0] == 3'(i)) begin
        inservice_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable    <= '0;
      mode      <= '0;
      pending   <= '0;
      inservice <= '0;
      hwint     <= '0;
    end else begin
      if (wr && offset == IRQ_ENABLE) enable <= wdata[N_IRQ-1:0];
      if (wr && offset == IRQ_MODE)   mode   <= wdata[N_IRQ-1:0];
      pending   <= pending_nxt;
      inservice <= inservice_nxt;
      // Driven from the current registers, so hwint trails them by one cycle.
      hwint     <= candidate;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      IRQ_ENABLE:    rdata[N_IRQ-1:0] = enable;
      IRQ_MODE:      rdata[N_IRQ-1:0] = mode;
      IRQ_PENDING:   rdata[N_IRQ-1:0] = pending;
      IRQ_CLAIM: begin
        rdata[CLAIM_VALID_BIT] = claim.valid;
        rdata[2:0]             = claim.id;
      end
      IRQ_INSERVICE: rdata[N_IRQ-1:0] = inservice;
      default:       rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        sel, we, re;
  logic [2:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;
  logic [5:0]  hwint;

  int n_checks = 0;
  int n_errors = 0;

  irq_controller #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .sel    (sel),
    .we     (we),
    .re     (re),
    .addr   (addr),
    .be     (be),
    .wdata  (wdata),
    .rdata  (rdata),
    .hwint  (hwint)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // History of sampled irq_in values, newest first. The synchronised level is
  // the sample taken SYNC_STAGES-1 edges ago; the one before it is the
  // previous level, which together give the rising edge.
  bit [5:0] m_hist[$];
  bit [5:0] m_en, m_md, m_pend, m_insv, m_hw;

  task automatic model_reset();
    m_hist = {};
    repeat (SYNC_STAGES + 1) m_hist.push_back(6'd0);
    m_en = 0; m_md = 0; m_pend = 0; m_insv = 0; m_hw = 0;
  endtask

  // Walk up from the highest priority: an in-service source stops the search.
  function automatic int model_claim();
    for (int i = 0; i < 6; i++) begin
      if (m_insv[i]) return -1;
      if (m_pend[i] && m_en[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit [5:0] model_lines();
    bit [5:0] r = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_insv[i]) break;
      r[i] = m_pend[i] & m_en[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] a);
    int cid = model_claim();
    case (a)
      3'd0: return {26'd0, m_en};
      3'd1: return {26'd0, m_md};
      3'd2: return {26'd0, m_pend};
      3'd3: return (cid >= 0) ? (32'h8000_0000 | 32'(cid)) : 32'd0;
      3'd5: return {26'd0, m_insv};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    bit       wr = sel && we && be[0];
    int       cid = model_claim();
    bit       clm = sel && re && addr == 3'd3 && cid >= 0;
    bit [5:0] s = m_hist[SYNC_STAGES-1];
    bit [5:0] prv = m_hist[SYNC_STAGES];
    bit [5:0] np = m_pend, ni = m_insv;
    for (int i = 0; i < 6; i++) begin
      if (m_md[i]) begin
        if (wr && addr == 3'd2 && wdata[i]) np[i] = 0;
        if (clm && cid == i) np[i] = 0;
        if ((s[i] && !prv[i]) || (wr && addr == 3'd6 && wdata[i])) np[i] = 1;
      end else begin
        np[i] = s[i];
      end
    end
    if (clm) ni[cid] = 1;
    if (wr && addr == 3'd4 && wdata[2:0] < 3'd6) ni[wdata[2:0]] = 0;
    m_hw = model_lines();
    if (wr && addr == 3'd0) m_en = wdata[5:0];
    if (wr && addr == 3'd1) m_md = wdata[5:0];
    m_pend = np;
    m_insv = ni;
    m_hist.push_front(irq_in);
    void'(m_hist.pop_back());
  endtask

  // ---------------- bus helpers ----------------
  task automatic idle();
    sel = 0; we = 0; re = 0; be = 4'h0; addr = 3'd0; wdata = 32'd0;
  endtask

  // Advance one edge; the model steps with the inputs held across that edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b = 4'h1);
    sel = 1; we = 1; be = b; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic claim_read(input string name, input logic [31:0] exp);
    sel = 1; re = 1; addr = IRQ_CLAIM;
    #1;
    check(name, rdata, exp);
    tick();
    idle();
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic do_reset();
    idle();
    irq_in = 6'd0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    irq_in = 6'd0;
    idle();

    // ---------------- reset state ----------------
    do_reset();
    check("rst_hwint", 32'(hwint), 32'd0);
    for (int a = 0; a < 8; a++) peek("rst_rdata", 3'(a), 32'd0);

    // ---------------- register table (irq_in idle) ----------------
    vecs.push_back('{"enable_rw",      IRQ_ENABLE,    32'h3F,        4'h1, IRQ_ENABLE,    32'h3F});
    vecs.push_back('{"mode_mask",      IRQ_MODE,      32'hFFFF_FFFF, 4'h1, IRQ_MODE,      32'h3F});
    vecs.push_back('{"be0_gate",       IRQ_ENABLE,    32'h00,        4'hE, IRQ_ENABLE,    32'h3F});
    vecs.push_back('{"enable_part",    IRQ_ENABLE,    32'h15,        4'h1, IRQ_ENABLE,    32'h15});
    vecs.push_back('{"off7_ignored",   IRQ_RESERVED,  32'h3F,        4'h1, IRQ_RESERVED,  32'h00});
    vecs.push_back('{"w1c_empty",      IRQ_PENDING,   32'h3F,        4'h1, IRQ_PENDING,   32'h00});
    vecs.push_back('{"swtrig_edge",    IRQ_SWTRIG,    32'h0A,        4'h1, IRQ_PENDING,   32'h0A});
    vecs.push_back('{"w1c_edge",       IRQ_PENDING,   32'h02,        4'h1, IRQ_PENDING,   32'h08});
    vecs.push_back('{"insv_ro",        IRQ_INSERVICE, 32'h3F,        4'h1, IRQ_INSERVICE, 32'h00});
    vecs.push_back('{"complete_idle",  IRQ_COMPLETE,  32'h02,        4'h1, IRQ_INSERVICE, 32'h00});
    vecs.push_back('{"claim_ro",       IRQ_CLAIM,     32'h3F,        4'h1, IRQ_CLAIM,     32'h00});
    vecs.push_back('{"mode_lag",       IRQ_MODE,      32'h00,        4'h1, IRQ_PENDING,   32'h08});
    vecs.push_back('{"swtrig_level",   IRQ_SWTRIG,    32'h3F,        4'h1, IRQ_PENDING,   32'h00});
    for (int v = 0; v < vecs.size(); v++) begin
      bus_write(vecs[v].addr, vecs[v].wdata, vecs[v].be);
      peek(vecs[v].name, vecs[v].rd_addr, vecs[v].exp);
    end

    // ---------------- edge pulse, latency, claim, complete ----------------
    do_reset();
    bus_write(IRQ_ENABLE, 32'h3F);
    bus_write(IRQ_MODE, 32'h3F);
    irq_in = 6'b000100;
    tick();                         // edge 0
    irq_in = 6'd0;
    tick();                         // edge 1
    tick();                         // edge 2
    check("lat_edge2_hwint", 32'(hwint), 32'h00);
    tick();                         // edge 3
    check("lat_edge3_hwint", 32'(hwint), 32'h04);
    peek("pend_after_pulse", IRQ_PENDING, 32'h04);
    claim_read("claim2", 32'h8000_0002);
    peek("insv_after_claim", IRQ_INSERVICE, 32'h04);
    peek("pend_after_claim", IRQ_PENDING, 32'h00);
    tick();
    check("hwint_after_claim", 32'(hwint), 32'h00);
    bus_write(IRQ_COMPLETE, 32'd2);
    peek("insv_after_complete", IRQ_INSERVICE, 32'h00);

    // ---------------- nesting ----------------
    irq_in = 6'b001000;
    tick();
    irq_in = 6'd0;
    repeat (2) tick();
    claim_read("claim3", 32'h8000_0003);
    irq_in = 6'b010010;
    tick();
    irq_in = 6'd0;
    repeat (3) tick();
    check("nest_hwint", 32'(hwint), 32'h02);
    claim_read("claim1", 32'h8000_0001);
    peek("nest_pend", IRQ_PENDING, 32'h10);
    bus_write(IRQ_COMPLETE, 32'd1);
    bus_write(IRQ_COMPLETE, 32'd3);
    check("nest_hold", 32'(hwint), 32'h00);
    tick();
    check("nest_release", 32'(hwint), 32'h10);
    peek("nest_insv", IRQ_INSERVICE, 32'h00);

    // ---------------- level mode ----------------
    do_reset();
    bus_write(IRQ_ENABLE, 32'h3F);
    irq_in = 6'b000001;
    repeat (4) tick();
    check("level_hwint", 32'(hwint), 32'h01);
    claim_read("claim0", 32'h8000_0000);
    peek("level_pend_kept", IRQ_PENDING, 32'h01);
    peek("level_insv", IRQ_INSERVICE, 32'h01);
    irq_in = 6'd0;
    repeat (2) tick();
    peek("level_drop_early", IRQ_PENDING, 32'h01);
    tick();
    peek("level_drop", IRQ_PENDING, 32'h00);

    // ---------------- collisions and SWTRIG ----------------
    do_reset();
    bus_write(IRQ_ENABLE, 32'h3E);
    bus_write(IRQ_MODE, 32'h3F);
    irq_in = 6'b100000;
    repeat (2) tick();              // rise pulse is present in this cycle
    bus_write(IRQ_PENDING, 32'h20);
    peek("set_beats_w1c", IRQ_PENDING, 32'h20);
    irq_in = 6'd0;
    bus_write(IRQ_SWTRIG, 32'h01);
    peek("swtrig_pend", IRQ_PENDING, 32'h21);
    tick();
    check("swtrig_masked", 32'(hwint), 32'h20);
    bus_write(IRQ_PENDING, 32'h20);
    peek("w1c_later", IRQ_PENDING, 32'h01);

    // ---------------- asynchronous reset mid-cycle ----------------
    bus_write(IRQ_ENABLE, 32'h3F);
    bus_write(IRQ_SWTRIG, 32'h3F);
    tick();
    check("all_hwint", 32'(hwint), 32'h3F);
    #2;
    reset = 1;
    #1;
    check("async_hwint", 32'(hwint), 32'h00);
    for (int a = 0; a < 8; a++) peek("async_rdata", 3'(a), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    idle();
    claim_read("claim_empty", 32'd0);
    peek("empty_insv", IRQ_INSERVICE, 32'h00);
    peek("empty_pend", IRQ_PENDING, 32'h00);

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 6'($urandom_range(1, 63));
      case ($urandom_range(0, 5))
        0, 1: begin
          sel = 1; we = 1;
          be = ($urandom_range(0, 7) != 0) ? 4'hF : 4'hE;
          addr = 3'($urandom);
          wdata = $urandom;
          if (addr == IRQ_COMPLETE) wdata[2:0] = 3'($urandom_range(0, 7));
        end
        2, 3: begin
          sel = 1; re = 1; addr = IRQ_CLAIM;
        end
        default: begin
          addr = 3'($urandom);
          sel = 1'($urandom);
          re = 1'($urandom);
        end
      endcase
      #2;
      check("rand_rdata", rdata, model_rdata(addr));
      check("rand_hwint", 32'(hwint), 32'(m_hw));
      tick();
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
